// File: rtl/bmp_header_writer.sv
// Writes the 54-byte BMP file + info header for a capture region into frame-store memory.
// Optional macro BMP_HDR_RES_EN: fills the resolution fields with 2835 px/m instead of zero.
module bmp_header_writer #(
  parameter int          ADDR_W    = 24,
  parameter int unsigned BASE_ADDR = 0,
  parameter int          BPP       = 24,
  parameter int          COORD_W   = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err,
  input  logic [COORD_W-1:0] xMin,
  input  logic [COORD_W-1:0] xMax,
  input  logic [COORD_W-1:0] yMin,
  input  logic [COORD_W-1:0] yMax,
  output logic [ADDR_W-1:0]  addr,
  output logic               wren,
  output logic [7:0]         wrdata,
  input  logic               wait_req
);

  generate
    if (BPP != 24 && BPP != 32) begin : g_bpp_check
      $error("bmp_header_writer: BPP must be 24 or 32");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, WRITE, DONE} state_t;

  localparam logic [5:0] LAST_IDX = 6'd53;

  state_t             state_reg, state_next;
  logic [5:0]         idx_reg, idx_next;
  logic [COORD_W-1:0] x_min_reg, x_min_next, x_max_reg, x_max_next;
  logic [COORD_W-1:0] y_min_reg, y_min_next, y_max_reg, y_max_next;
  logic [COORD_W:0]   w_reg, w_next, h_reg, h_next;
  logic [31:0]        img_reg, img_next, file_reg, file_next;
  logic               err_reg, err_next;

  logic [COORD_W:0]   w_calc, h_calc;
  logic [31:0]        row_calc, pad_calc, img_calc;
  logic               region_bad;

  // Geometry is derived from the latched bounds, so input changes after start are harmless.
  assign w_calc     = {1'b0, x_max_reg} - {1'b0, x_min_reg} + {{COORD_W{1'b0}}, 1'b1};
  assign h_calc     = {1'b0, y_max_reg} - {1'b0, y_min_reg} + {{COORD_W{1'b0}}, 1'b1};
  assign row_calc   = 32'(w_calc) * 32'(BPP / 8);
  assign pad_calc   = (row_calc + 32'd3) & ~32'd3;
  assign img_calc   = pad_calc * 32'(h_calc);
  assign region_bad = (x_max_reg < x_min_reg) || (y_max_reg < y_min_reg);

  logic [63:0] res_field;
`ifdef BMP_HDR_RES_EN
  assign res_field = 64'h0000_0B13_0000_0B13;
`else
  assign res_field = 64'h0;
`endif

  // Whole header as one little-endian vector: byte 0 sits in the low bits.
  logic [431:0] hdr_vec;
  assign hdr_vec = {64'h0, res_field, img_reg, 32'h0, 16'(BPP), 16'd1,
                    32'(h_reg), 32'(w_reg), 32'd40, 32'd54, 32'h0, file_reg, 16'h4D42};

  logic [7:0] hdr_bytes [0:63];
  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_hdr_bytes
      if (gi < 54) begin : g_used
        assign hdr_bytes[gi] = hdr_vec[gi*8 +: 8];
      end else begin : g_unused
        assign hdr_bytes[gi] = 8'h00;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      x_min_reg <= '0;
      x_max_reg <= '0;
      y_min_reg <= '0;
      y_max_reg <= '0;
      w_reg     <= '0;
      h_reg     <= '0;
      img_reg   <= '0;
      file_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      x_min_reg <= x_min_next;
      x_max_reg <= x_max_next;
      y_min_reg <= y_min_next;
      y_max_reg <= y_max_next;
      w_reg     <= w_next;
      h_reg     <= h_next;
      img_reg   <= img_next;
      file_reg  <= file_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    x_min_next = x_min_reg;
    x_max_next = x_max_reg;
    y_min_next = y_min_reg;
    y_max_next = y_max_reg;
    w_next     = w_reg;
    h_next     = h_reg;
    img_next   = img_reg;
    file_next  = file_reg;
    err_next   = err_reg;
    busy       = 1'b0;
    done       = 1'b0;
    wren       = 1'b0;
    addr       = '0;
    wrdata     = 8'h00;
    case (state_reg)
      IDLE, DONE: begin
        done = (state_reg == DONE);
        if (start) begin
          x_min_next = xMin;
          x_max_next = xMax;
          y_min_next = yMin;
          y_max_next = yMax;
          state_next = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (region_bad) begin
          err_next   = 1'b1;
          state_next = DONE;
        end else begin
          err_next   = 1'b0;
          idx_next   = '0;
          w_next     = w_calc;
          h_next     = h_calc;
          img_next   = img_calc;
          file_next  = img_calc + 32'd54;
          state_next = WRITE;
        end
      end
      WRITE: begin
        busy   = 1'b1;
        wren   = 1'b1;
        addr   = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_reg);
        wrdata = hdr_bytes[idx_reg];
        if (!wait_req) begin
          if (idx_reg == LAST_IDX) begin
            state_next = DONE;
          end else begin
            idx_next = idx_reg + 6'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign err = err_reg;

endmodule

// File: tb/tb_bmp_header_writer.sv
// Bench for bmp_header_writer: a 24-bpp instance at base 0 and a 32-bpp instance at base 0x100.
module tb_bmp_header_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] xMin, xMax, yMin, yMax;
  logic        start0, start1, wait_req0, wait_req1;
  logic        busy0, done0, err0, wren0, busy1, done1, err1, wren1;
  logic [23:0] addr0, addr1;
  logic [7:0]  wrdata0, wrdata1;

  always #5 clk = ~clk;

  bmp_header_writer dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0), .err(err0),
    .xMin(xMin), .xMax(xMax), .yMin(yMin), .yMax(yMax),
    .addr(addr0), .wren(wren0), .wrdata(wrdata0), .wait_req(wait_req0)
  );

  bmp_header_writer #(.BPP(32), .BASE_ADDR(32'h100)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1), .err(err1),
    .xMin(xMin), .xMax(xMax), .yMin(yMin), .yMax(yMax),
    .addr(addr1), .wren(wren1), .wrdata(wrdata1), .wait_req(wait_req1)
  );

  typedef struct {
    logic [23:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    int sel;
    int xmin, xmax, ymin, ymax;
    bit stall;
    int exp_lat;
    bit exp_err;
    int exp_w, exp_h;
    int exp_img, exp_file;
  } vec_t;

  wr_t q0[$], q1[$];
  int  acc0 = 0, acc1 = 0;
  int  checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Expected header built from hand-computed sizes, not from the DUT's arithmetic.
  task automatic push_expected(input int sel, input int w, input int h, input int img, input int file);
    logic [7:0] b [54];
    int bpp, base;
    bpp  = sel ? 32 : 24;
    base = sel ? 32'h100 : 0;
    for (int k = 0; k < 54; k++) b[k] = 8'h00;
    b[0] = 8'h42;
    b[1] = 8'h4D;
    for (int i = 0; i < 4; i++) begin
      b[2+i]  = 8'(file >> (8*i));
      b[10+i] = 8'(54 >> (8*i));
      b[14+i] = 8'(40 >> (8*i));
      b[18+i] = 8'(w >> (8*i));
      b[22+i] = 8'(h >> (8*i));
      b[34+i] = 8'(img >> (8*i));
    end
    b[26] = 8'd1;
    b[28] = 8'(bpp);
`ifdef BMP_HDR_RES_EN
    b[38] = 8'h13; b[39] = 8'h0B; b[42] = 8'h13; b[43] = 8'h0B;
`endif
    for (int k = 0; k < 54; k++) begin
      wr_t e;
      e.addr = 24'(base + k);
      e.data = b[k];
      if (sel) q1.push_back(e); else q0.push_back(e);
    end
  endtask

  // Write monitors: compare every presented byte with the queue head; pop on acceptance.
  always @(negedge clk) begin
    if (rst_n && wren0) begin
      if (q0.size() == 0) begin
        check("dut0_unexpected_write", 64'(addr0), 64'hFFFF_FFFF);
      end else begin
        check("dut0_addr", 64'(addr0), 64'(q0[0].addr));
        check("dut0_data", 64'(wrdata0), 64'(q0[0].data));
        if (!wait_req0) begin
          void'(q0.pop_front());
          acc0++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && wren1) begin
      if (q1.size() == 0) begin
        check("dut1_unexpected_write", 64'(addr1), 64'hFFFF_FFFF);
      end else begin
        check("dut1_addr", 64'(addr1), 64'(q1[0].addr));
        check("dut1_data", 64'(wrdata1), 64'(q1[0].data));
        if (!wait_req1) begin
          void'(q1.pop_front());
          acc1++;
        end
      end
    end
  end

  task automatic run_vec(input int num, input vec_t v);
    int  n;
    bit  got;
    logic d, bz, e, wr;
    logic [23:0] a;
    logic [7:0] wd;
    acc0 = 0;
    acc1 = 0;
    if (!v.exp_err) push_expected(v.sel, v.exp_w, v.exp_h, v.exp_img, v.exp_file);
    @(negedge clk);
    xMin = 11'(v.xmin); xMax = 11'(v.xmax); yMin = 11'(v.ymin); yMax = 11'(v.ymax);
    if (v.sel) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    xMin = 11'($urandom); xMax = 11'($urandom); yMin = 11'($urandom); yMax = 11'($urandom);
    d  = v.sel ? done1 : done0;
    bz = v.sel ? busy1 : busy0;
    check("done_after_start", 64'(d), 64'd0);
    check("busy_after_start", 64'(bz), 64'd1);
    n = 0;
    got = 1'b0;
    while (n < 200 && !got) begin
      wait_req0 = v.stall && (((n + 1) >= 12 && (n + 1) <= 14) || ((n + 1) >= 58 && (n + 1) <= 59));
      @(posedge clk);
      #1;
      n++;
      got = v.sel ? done1 : done0;
    end
    wait_req0 = 1'b0;
    if (!got) check("done_timeout", 64'(n), 64'(v.exp_lat));
    else      check("done_latency", 64'(n), 64'(v.exp_lat));
    e  = v.sel ? err1 : err0;
    wr = v.sel ? wren1 : wren0;
    a  = v.sel ? addr1 : addr0;
    wd = v.sel ? wrdata1 : wrdata0;
    check("err_flag", 64'(e), 64'(v.exp_err));
    check("accepted_writes", 64'(v.sel ? acc1 : acc0), 64'(v.exp_err ? 0 : 54));
    check("queue_drained", 64'(v.sel ? q1.size() : q0.size()), 64'd0);
    check("idle_wren", 64'(wr), 64'd0);
    check("idle_addr", 64'(a), 64'd0);
    check("idle_wrdata", 64'(wd), 64'd0);
    $display("vector %0d: dut%0d x=%0d..%0d y=%0d..%0d stall=%0d latency=%0d err=%0d writes=%0d",
             num, v.sel, v.xmin, v.xmax, v.ymin, v.ymax, v.stall, n, e, v.sel ? acc1 : acc0);
  endtask

  initial begin
    vec_t vecs [9];
    int n;
    vecs[0] = '{0, 0,   99, 0,   99, 0, 55, 0, 100,  100,  30000,    30054};
    vecs[1] = '{0, 0,    2, 0,    1, 0, 55, 0,   3,    2,     24,       78};
    vecs[2] = '{1, 0,    0, 0,    0, 0, 55, 0,   1,    1,      4,       58};
    vecs[3] = '{0, 10,  14, 3,    9, 1, 60, 0,   5,    7,    112,      166};
    vecs[4] = '{0, 9,    5, 0,    0, 0,  1, 1,   0,    0,      0,        0};
    vecs[5] = '{1, 2,    4, 0,    2, 0, 55, 0,   3,    3,     36,       90};
    vecs[6] = '{0, 0,    0, 7,    3, 0,  1, 1,   0,    0,      0,        0};
    vecs[7] = '{0, 1,    1, 0,    0, 0, 55, 0,   1,    1,      4,       58};
    vecs[8] = '{0, 0, 2047, 0, 2047, 0, 55, 0, 2048, 2048, 12582912, 12582966};

    rst_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0; wait_req0 = 1'b0; wait_req1 = 1'b0;
    xMin = '0; xMax = '0; yMin = '0; yMax = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy0", 64'(busy0), 64'd0);
    check("rst_done0", 64'(done0), 64'd0);
    check("rst_err0", 64'(err0), 64'd0);
    check("rst_wren0", 64'(wren0), 64'd0);
    check("rst_addr0", 64'(addr0), 64'd0);
    check("rst_wrdata0", 64'(wrdata0), 64'd0);
    check("rst_busy1", 64'(busy1), 64'd0);
    check("rst_done1", 64'(done1), 64'd0);
    check("rst_wren1", 64'(wren1), 64'd0);
    check("rst_addr1", 64'(addr1), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Reset while byte 20 is on the bus: it must not be accepted and writing must stop.
    acc0 = 0;
    push_expected(0, 100, 100, 30000, 30054);
    @(negedge clk);
    xMin = 11'd0; xMax = 11'd99; yMin = 11'd0; yMax = 11'd99;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    n = 0;
    while (n < 21) begin
      @(posedge clk);
      #1;
      n++;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_wren", 64'(wren0), 64'd0);
    check("midrst_busy", 64'(busy0), 64'd0);
    check("midrst_done", 64'(done0), 64'd0);
    check("midrst_accepted", 64'(acc0), 64'd20);
    $display("mid-write reset: accepted=%0d wren=%0d busy=%0d", acc0, wren0, busy0);
    q0.delete();
    rst_n = 1'b1;
    run_vec(9, vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bmp_header_writer.md
# bmp_header_writer

Generates the complete 54-byte BMP file header (BITMAPFILEHEADER + BITMAPINFOHEADER) for a rectangular capture region and writes it byte-by-byte into the frame-store memory. It sits between the capture controller and the memory write port and runs before pixel data is streamed out. It generalises the earlier header writer in four ways:
- parametrised address width, base address and pixel depth;
- correct 4-byte row padding;
- all 54 bytes written;
- memory back-pressure and region-error reporting.

## Interface
Parameters:
- ADDR_W, 24, memory address width
- BASE_ADDR, 0, address of header byte 0
- BPP, 24, bits per pixel; only 24 or 32 legal (elaboration-time assertion otherwise)
- COORD_W, 11, coordinate width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request header generation; sampled only in IDLE or DONE
- busy  out  1  high in CALC and WRITE
- done  out  1  level, high in DONE until next accepted start
- err  out  1  region invalid; valid while done=1
- xMin, xMax, yMin, yMax  in  COORD_W  inclusive region bounds
- addr  out  ADDR_W  write address = BASE_ADDR + byte index
- wren  out  1  write strobe
- wrdata  out  8  header byte
- wait_req  in  1  memory stall; a write is accepted on a clock edge where wren=1 and wait_req=0

## Operation
- States: IDLE → CALC → WRITE → DONE; DONE → CALC on start.
- IDLE/DONE + start: latch all four bounds, go to CALC. start in CALC/WRITE is ignored.
- CALC (1 cycle):
  - w = xMax−xMin+1; h = yMax−yMin+1 (COORD_W+1 bits).
  - row = w·BPP/8; pad = (row+3) & ~3; img = pad·h (32-bit); file = img+54.
  - If xMax<xMin or yMax<yMin: set err, go to DONE with no writes. Otherwise clear err, idx=0, go to WRITE.
- WRITE: wren=1, addr=BASE_ADDR+idx, wrdata=hdr[idx]. idx increments only on an accepted write; the state leaves to DONE on acceptance of idx 53.
- Header bytes (multi-byte fields little-endian):
  - 0–1: 0x42, 0x4D
  - 2–5: file
  - 6–9: 0
  - 10–13: 54
  - 14–17: 40
  - 18–21: w
  - 22–25: h (positive, bottom-up)
  - 26–27: 1
  - 28–29: BPP
  - 30–33: 0
  - 34–37: img
  - 38–45: resolution (see Configuration)
  - 46–53: 0
- addr/wrdata held stable while wait_req=1.
- Outside WRITE: wren=0, addr=0, wrdata=0.

## Timing
- Reset values: state IDLE; busy=0, done=0, err=0, wren=0, addr=0, wrdata=0.
- Reset takes priority at any point, including mid-WRITE: wren=0 from the next cycle and no further writes; latched bounds discarded.
- Latency with wait_req=0: start sampled at edge E0; CALC after E0; wren first high after E1; byte k accepted at E(k+2); done=1 after E55.
- Each cycle of wait_req=1 during WRITE adds exactly one cycle.
- Error path: done=1, err=1 after E1.
- start with done=1: done drops after the same edge; the sequence restarts identically.
- Simultaneous wait_req=1 on the final byte: remain in WRITE; no done until acceptance.
- Bounds may change after start is sampled without effect.

## Configuration
- BMP_HDR_RES_EN defined:
  - bytes 38–41 and 42–45 = 2835 px/m (0x13, 0x0B, 0x00, 0x00) each.
- Undefined:
  - bytes 38–45 = 0.
- No other difference.

## Test plan
- 100×100 region (0..99), BPP=24, no stall:
  - 54 writes at addr 0..53.
  - bytes 2–5 = 0x66, 0x75, 0x00, 0x00 (file 30054).
  - bytes 18 = 0x64, 22 = 0x64, 34–35 = 0x30, 0x75.
  - done after E55.
- x 0..2, y 0..1, BPP=24 (row 9 → pad 12):
  - img = 24, file = 78.
  - bytes 2 = 0x4E, 34 = 0x18, 28 = 0x18.
- BPP=32, BASE_ADDR=0x100, region 0..0 × 0..0:
  - addr 0x100..0x135.
  - img = 4, file = 58 (byte 2 = 0x3A), byte 28 = 0x20.
- wait_req high for 3 cycles at idx 10 and on idx 53:
  - addr/wrdata held through each stall.
  - done delayed 3 + n cycles.
  - exactly 54 accepted writes.
- xMax=5, xMin=9: zero writes; done=1, err=1 after E1.
- rst_n low at idx 20:
  - wren=0 from the next cycle, state IDLE.
  - A new start produces a full clean 54-byte sequence.
- With BMP_HDR_RES_EN: bytes 38–45 = 13 0B 00 00 13 0B 00 00. Without it: all zero.
